ad_hd_vd_generation: RTL and testbench

Upstream driver of the AD9970 timing stage. Generates the HD/VD pulse pair that the AFE timing generator edge-detects to reset its horizontal counter and start frames. Line length, frame length and pulse widths are programmable and take effect only at frame boundaries. Start/stop is frame-clean.

---
 rtl/ad_hd_vd_generation_pkg.sv | 18 +
 rtl/ad_param_shadow.sv | 60 ++++++
 rtl/ad_hd_vd_generation.sv | 121 ++++++++++++
 tb/tb_ad_hd_vd_generation.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ad_hd_vd_generation_pkg.sv
// Shared constants and FSM encoding for the HD/VD pulse generator.
package ad_hd_vd_generation_pkg;

  localparam int HCNT_W_DEF   = 13;
  localparam int VCNT_W_DEF   = 13;
  localparam int MIN_LINE_DEF = 16;

  // Smallest legal frame length and pulse width after clamping
  localparam int MIN_FRAME    = 2;
  localparam int MIN_WIDTH    = 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_PEND = 2'd2
  } state_e;

endpackage

// File: rtl/ad_param_shadow.sv
// Clamps the four timing fields and holds them stable for a whole frame.
module ad_param_shadow
  import ad_hd_vd_generation_pkg::*;
#(
  parameter int HCNT_W   = HCNT_W_DEF,
  parameter int VCNT_W   = VCNT_W_DEF,
  parameter int MIN_LINE = MIN_LINE_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic [HCNT_W-1:0] line_length_i,
  input  logic [HCNT_W-1:0] hd_width_i,
  input  logic [VCNT_W-1:0] frame_lines_i,
  input  logic [VCNT_W-1:0] vd_width_i,
  output logic [HCNT_W-1:0] line_length_o,
  output logic [HCNT_W-1:0] hd_width_o,
  output logic [VCNT_W-1:0] frame_lines_o,
  output logic [VCNT_W-1:0] vd_width_o
);

  logic [HCNT_W-1:0] l_c, wh_c;
  logic [VCNT_W-1:0] f_c, wv_c;
  logic [HCNT_W-1:0] l_q, wh_q;
  logic [VCNT_W-1:0] f_q, wv_q;

  // Clamp: widths are limited against the already-clamped lengths so a
  // pulse can never cover the whole period (one falling edge per period).
  always_comb begin
    l_c  = (line_length_i < HCNT_W'(MIN_LINE)) ? HCNT_W'(MIN_LINE) : line_length_i;
    wh_c = hd_width_i;
    if (hd_width_i == '0)       wh_c = HCNT_W'(MIN_WIDTH);
    else if (hd_width_i >= l_c) wh_c = l_c - HCNT_W'(1);
    f_c  = (frame_lines_i < VCNT_W'(MIN_FRAME)) ? VCNT_W'(MIN_FRAME) : frame_lines_i;
    wv_c = vd_width_i;
    if (vd_width_i == '0)       wv_c = VCNT_W'(MIN_WIDTH);
    else if (vd_width_i >= f_c) wv_c = f_c - VCNT_W'(1);
  end

  // Shadow load only at start of run or on the last clock of a frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l_q  <= '0;
      wh_q <= '0;
      f_q  <= '0;
      wv_q <= '0;
    end else if (load_i) begin
      l_q  <= l_c;
      wh_q <= wh_c;
      f_q  <= f_c;
      wv_q <= wv_c;
    end
  end

  assign line_length_o = l_q;
  assign hd_width_o    = wh_q;
  assign frame_lines_o = f_q;
  assign vd_width_o    = wv_q;

endmodule

// File: rtl/ad_hd_vd_generation.sv
// HD/VD pulse generator feeding the AD9970 timing stage. Frame-clean
// start/stop, parameters latched at frame boundaries.
module ad_hd_vd_generation
  import ad_hd_vd_generation_pkg::*;
#(
  parameter int HCNT_W   = HCNT_W_DEF,
  parameter int VCNT_W   = VCNT_W_DEF,
  parameter int MIN_LINE = MIN_LINE_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_enable,
  input  logic [HCNT_W-1:0] iv_line_length,
  input  logic [HCNT_W-1:0] iv_hd_width,
  input  logic [VCNT_W-1:0] iv_frame_lines,
  input  logic [VCNT_W-1:0] iv_vd_width,
  output logic              o_hd,
  output logic              o_vd,
  output logic              o_line_start,
  output logic              o_frame_start,
  output logic [VCNT_W-1:0] ov_vcount,
  output logic              o_busy
);

  state_e            state_q;
  logic [HCNT_W-1:0] hcnt_q;
  logic [VCNT_W-1:0] vcnt_q;
  logic [HCNT_W-1:0] l_s, wh_s;
  logic [VCNT_W-1:0] f_s, wv_s;
  logic              running, line_end, frame_end, load;
  logic              hd_q, vd_q, ls_q, fs_q;
  logic [VCNT_W-1:0] vcount_q;

  assign running   = (state_q != ST_IDLE);
  assign line_end  = (hcnt_q == l_s - HCNT_W'(1));
  assign frame_end = running && line_end && (vcnt_q == f_s - VCNT_W'(1));
  assign load      = ((state_q == ST_IDLE) && i_enable) || frame_end;

  ad_param_shadow #(
    .HCNT_W   (HCNT_W),
    .VCNT_W   (VCNT_W),
    .MIN_LINE (MIN_LINE)
  ) u_shadow (
    .clk           (clk),
    .reset_n       (reset_n),
    .load_i        (load),
    .line_length_i (iv_line_length),
    .hd_width_i    (iv_hd_width),
    .frame_lines_i (iv_frame_lines),
    .vd_width_i    (iv_vd_width),
    .line_length_o (l_s),
    .hd_width_o    (wh_s),
    .frame_lines_o (f_s),
    .vd_width_o    (wv_s)
  );

  // FSM and raster counters; a stop request only takes effect at frame end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      if (running) begin
        if (line_end) begin
          hcnt_q <= '0;
          vcnt_q <= frame_end ? '0 : vcnt_q + VCNT_W'(1);
        end else begin
          hcnt_q <= hcnt_q + HCNT_W'(1);
        end
      end
      case (state_q)
        ST_IDLE: begin
          hcnt_q <= '0;
          vcnt_q <= '0;
          if (i_enable) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (!i_enable) state_q <= frame_end ? ST_IDLE : ST_STOP_PEND;
        end
        ST_STOP_PEND: begin
          if (i_enable)       state_q <= ST_RUN;
          else if (frame_end) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output stage: one clock behind the counters, forced inactive when idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hd_q     <= 1'b1;
      vd_q     <= 1'b1;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      vcount_q <= '0;
    end else begin
      vcount_q <= vcnt_q;
      if (running) begin
        hd_q <= !(hcnt_q < wh_s);
        vd_q <= !(vcnt_q < wv_s);
        ls_q <= (hcnt_q == '0);
        fs_q <= (hcnt_q == '0) && (vcnt_q == '0);
      end else begin
        hd_q <= 1'b1;
        vd_q <= 1'b1;
        ls_q <= 1'b0;
        fs_q <= 1'b0;
      end
    end
  end

  assign o_hd          = hd_q;
  assign o_vd          = vd_q;
  assign o_line_start  = ls_q;
  assign o_frame_start = fs_q;
  assign ov_vcount     = vcount_q;
  assign o_busy        = running;

endmodule

// File: tb/tb_ad_hd_vd_generation.sv
// Scoreboard bench for ad_hd_vd_generation: a position-based raster model
// queues the expected outputs for every clock and they are compared after
// the edge.
module tb_ad_hd_vd_generation;

  localparam int HW = 13;
  localparam int VW = 13;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_enable;
  logic [HW-1:0] iv_line_length, iv_hd_width;
  logic [VW-1:0] iv_frame_lines, iv_vd_width;
  logic          o_hd, o_vd, o_line_start, o_frame_start, o_busy;
  logic [VW-1:0] ov_vcount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int hd, vd, ls, fs, vc, busy;
  } exp_t;
  exp_t sb_q[$];

  // Model: state (0 idle, 1 run, 2 stop pending), clock position in frame
  int mst, mpos, mL, mWh, mF, mWv;

  ad_hd_vd_generation dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_enable       (i_enable),
    .iv_line_length (iv_line_length),
    .iv_hd_width    (iv_hd_width),
    .iv_frame_lines (iv_frame_lines),
    .iv_vd_width    (iv_vd_width),
    .o_hd           (o_hd),
    .o_vd           (o_vd),
    .o_line_start   (o_line_start),
    .o_frame_start  (o_frame_start),
    .ov_vcount      (ov_vcount),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_load();
    int l, f;
    l   = (int'(iv_line_length) < 16) ? 16 : int'(iv_line_length);
    mWh = (iv_hd_width == 0) ? 1 : ((int'(iv_hd_width) >= l) ? l - 1 : int'(iv_hd_width));
    f   = (int'(iv_frame_lines) < 2) ? 2 : int'(iv_frame_lines);
    mWv = (iv_vd_width == 0) ? 1 : ((int'(iv_vd_width) >= f) ? f - 1 : int'(iv_vd_width));
    mL  = l;
    mF  = f;
  endtask

  task automatic model_reset();
    mst = 0; mpos = 0; mL = 0; mWh = 0; mF = 0; mWv = 0;
    sb_q.delete();
  endtask

  // One clock: predict, push, advance, pop and compare
  task automatic tick();
    exp_t e, g;
    bit   last;
    int   hc, vc;
    hc = 0; vc = 0;
    if (mst != 0) begin
      hc = mpos % mL;
      vc = mpos / mL;
    end
    e.hd = (mst != 0) ? int'(hc >= mWh) : 1;
    e.vd = (mst != 0) ? int'(vc >= mWv) : 1;
    e.ls = (mst != 0) ? int'(hc == 0) : 0;
    e.fs = (mst != 0) ? int'(mpos == 0) : 0;
    e.vc = vc;
    last = (mst != 0) && (mpos == mL * mF - 1);
    if (mst == 0) begin
      if (i_enable) begin
        model_load();
        mst = 1; mpos = 0;
      end
    end else begin
      if (last) begin
        model_load();
        mpos = 0;
      end else mpos++;
      if (mst == 1 && !i_enable)      mst = last ? 0 : 2;
      else if (mst == 2 && i_enable)  mst = 1;
      else if (mst == 2 && last)      mst = 0;
    end
    e.busy = int'(mst != 0);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    chk("hd", int'(o_hd), g.hd);
    chk("vd", int'(o_vd), g.vd);
    chk("line_start", int'(o_line_start), g.ls);
    chk("frame_start", int'(o_frame_start), g.fs);
    chk("vcount", int'(ov_vcount), g.vc);
    chk("busy", int'(o_busy), g.busy);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the model sits at the start of the given line (bounded)
  task automatic wait_line(input int line, input int bound);
    int n;
    n = 0;
    while (!(mst != 0 && (mpos % mL) == 0 && (mpos / mL) == line) && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) chk("wait_line_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (mst != 0 && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic set_params(input int l, input int wh, input int f, input int wv);
    iv_line_length = HW'(l);
    iv_hd_width    = HW'(wh);
    iv_frame_lines = VW'(f);
    iv_vd_width    = VW'(wv);
  endtask

  initial begin
    model_reset();
    reset_n  = 1'b0;
    i_enable = 1'b0;
    set_params(100, 8, 10, 2);
    #22;
    chk("rst_hd", int'(o_hd), 1);
    chk("rst_vd", int'(o_vd), 1);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_vcount", int'(ov_vcount), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run(5);

    // Nominal raster, then L change mid frame 3 (index 2)
    i_enable = 1'b1;
    run(2500);
    iv_line_length = HW'(120);
    run(2500);

    // Stop requested in line 4: lines 5..9 finish, then idle
    wait_line(4, 3000);
    i_enable = 1'b0;
    wait_idle(2000);
    run(10);

    // Stop requested at line 4, cancelled at line 6: back-to-back frames
    i_enable = 1'b1;
    wait_line(4, 3000);
    i_enable = 1'b0;
    wait_line(6, 3000);
    i_enable = 1'b1;
    wait_line(2, 3000);
    run(50);

    // Clamping of out-of-range fields
    i_enable = 1'b0;
    wait_idle(3000);
    set_params(5, 0, 1, 7);
    run(3);
    i_enable = 1'b1;
    run(100);

    // Async reset while HD is low, no clock edge needed
    set_params(100, 8, 10, 2);
    i_enable = 1'b0;
    wait_idle(200);
    i_enable = 1'b1;
    run(305);
    #2;
    chk("pre_rst_hd_low", int'(o_hd), 0);
    reset_n = 1'b0;
    #1;
    chk("async_hd", int'(o_hd), 1);
    chk("async_vd", int'(o_vd), 1);
    chk("async_busy", int'(o_busy), 0);
    chk("async_ls", int'(o_line_start), 0);
    model_reset();
    i_enable = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    run(20);
    i_enable = 1'b1;
    run(150);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
